// File: rtl/sobel_pkg.sv
// Shared types for the streaming Sobel accelerator: FSM states, pixel/word
// typedefs and a word-to-pixel unpacking helper.
package sobel_pkg;

  localparam int PIX_PER_WORD = 4;

  typedef logic [7:0]                   pixel_t;
  typedef logic [31:0]                  word_t;
  typedef logic [PIX_PER_WORD-1:0][7:0] pix_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    ZTOP,
    RD,
    WR,
    FLUSH,
    ZBOT,
    DONE
  } state_t;

  // Byte k of a word is the pixel at column 4c+k (byte 0 = LSBs).
  function automatic pix_vec_t unpack_word(input word_t w);
    pix_vec_t v;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      v[k] = w[8*k +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Sobel 3x3 kernel for one pixel: |Gx| + |Gy| saturated to 8 bits.
// The centre pixel carries zero weight and is therefore not a port.
module sobel_kernel
  import sobel_pkg::*;
(
  input  pixel_t p00,
  input  pixel_t p01,
  input  pixel_t p02,
  input  pixel_t p10,
  input  pixel_t p12,
  input  pixel_t p20,
  input  pixel_t p21,
  input  pixel_t p22,
  output pixel_t mag
);

  logic signed [11:0] gx;
  logic signed [11:0] gy;
  logic        [11:0] sum;

  function automatic logic signed [11:0] widen(input pixel_t p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic [11:0] abs12(input logic signed [11:0] v);
    return v[11] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic pixel_t sat8(input logic [11:0] v);
    return (v > 12'd255) ? 8'hFF : v[7:0];
  endfunction

  always_comb begin
    gx  = (widen(p02) + (widen(p12) <<< 1) + widen(p22))
        - (widen(p00) + (widen(p10) <<< 1) + widen(p20));
    gy  = (widen(p20) + (widen(p21) <<< 1) + widen(p22))
        - (widen(p00) + (widen(p01) <<< 1) + widen(p02));
    sum = abs12(gx) + abs12(gy);
    mag = sat8(sum);
  end

endmodule

// File: rtl/sobel_linebuf.sv
// Two-row line buffer: synchronous read one cycle after the address, and a
// write that shifts row1[addr] into row0[addr] while storing new data in row1.
module sobel_linebuf
  import sobel_pkg::*;
#(
  parameter int WORDS = 88,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rd0,
  output word_t         rd1
);

  word_t row0_q [WORDS];
  word_t row1_q [WORDS];
  word_t rd0_q;
  word_t rd1_q;

  always_ff @(posedge clk) begin
    if (re) begin
      rd0_q <= row0_q[addr];
      rd1_q <= row1_q[addr];
    end
    if (we) begin
      row0_q[addr] <= row1_q[addr];
      row1_q[addr] <= wdata;
    end
  end

  assign rd0 = rd0_q;
  assign rd1 = rd1_q;

endmodule

// File: rtl/sobel_stream_acc.sv
// Streaming Sobel accelerator: reads each source word once, writes the edge
// image with zero borders. Optional binarisation via macro SOBEL_THRESH_EN.
module sobel_stream_acc
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = IMG_W * IMG_H / 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataR,
  output logic [31:0]       dataW,
  output logic              en,
  output logic              we,
  input  logic              start,
`ifdef SOBEL_THRESH_EN
  input  logic [7:0]        thresh,
`endif
  output logic              finish
);

  localparam int WORDS = IMG_W / PIX_PER_WORD;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW    = $clog2(IMG_H + 1);

  state_t            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

  word_t  win_cur_q  [3];
  word_t  win_cur_d  [3];
  pixel_t win_left_q [3];
  pixel_t win_left_d [3];
  logic   win_upd;

  word_t  lb_rd0, lb_rd1;
  logic   lb_re, lb_we;
  word_t  new_w [3];
  logic [5:0][7:0] row_pix [3];
  pixel_t lane_mag [PIX_PER_WORD];
  word_t  out_w;
  logic   first_word, last_word;

  sobel_linebuf #(
    .WORDS (WORDS),
    .AW    (CW)
  ) u_linebuf (
    .clk   (clk),
    .re    (lb_re),
    .we    (lb_we),
    .addr  (c_q),
    .wdata (dataR),
    .rd0   (lb_rd0),
    .rd1   (lb_rd1)
  );

  assign new_w[0] = lb_rd0;
  assign new_w[1] = lb_rd1;
  assign new_w[2] = dataR;

  // Per window row: left neighbour pixel, four current pixels, right neighbour
  // pixel (zero past the right edge during FLUSH).
  for (genvar i = 0; i < 3; i++) begin : g_row
    pix_vec_t cur_v;
    pixel_t   right_pix;
    assign cur_v      = unpack_word(win_cur_q[i]);
    assign right_pix  = (state_q == FLUSH) ? 8'h00 : new_w[i][7:0];
    assign row_pix[i] = {right_pix, cur_v, win_left_q[i]};
  end

  for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_lane
    sobel_kernel u_kernel (
      .p00 (row_pix[0][k]),
      .p01 (row_pix[0][k+1]),
      .p02 (row_pix[0][k+2]),
      .p10 (row_pix[1][k]),
      .p12 (row_pix[1][k+2]),
      .p20 (row_pix[2][k]),
      .p21 (row_pix[2][k+1]),
      .p22 (row_pix[2][k+2]),
      .mag (lane_mag[k])
    );
  end

  assign first_word = (state_q == WR) && (c_q == CW'(1));
  assign last_word  = (state_q == FLUSH);

  always_comb begin
    out_w = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
`ifdef SOBEL_THRESH_EN
      out_w[8*k +: 8] = (lane_mag[k] >= thresh) ? 8'hFF : 8'h00;
`else
      out_w[8*k +: 8] = lane_mag[k];
`endif
    end
    if (first_word) out_w[7:0]   = 8'h00;
    if (last_word)  out_w[31:24] = 8'h00;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_cur_d[i]  = win_upd ? new_w[i]            : win_cur_q[i];
      win_left_d[i] = win_upd ? win_cur_q[i][31:24] : win_left_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    en       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    dataW    = '0;
    finish   = 1'b0;
    lb_re    = 1'b0;
    lb_we    = 1'b0;
    win_upd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d      = '0;
          c_d      = '0;
          rd_ptr_d = ADDR_W'(SRC_BASE);
          wr_ptr_d = ADDR_W'(DST_BASE);
          state_d  = ZTOP;
        end
      end
      ZTOP, ZBOT: begin
        en       = 1'b1;
        we       = 1'b1;
        addr     = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (c_q == CW'(WORDS - 1)) begin
          c_d     = '0;
          state_d = (state_q == ZTOP) ? RD : DONE;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      RD: begin
        en       = 1'b1;
        addr     = rd_ptr_q;
        rd_ptr_d = rd_ptr_q + 1'b1;
        lb_re    = 1'b1;
        state_d  = WR;
      end
      WR: begin
        lb_we   = 1'b1;
        win_upd = 1'b1;
        // Output lags the read column by one word so the right neighbour exists.
        if (r_q >= RW'(2) && c_q != '0) begin
          en       = 1'b1;
          we       = 1'b1;
          addr     = wr_ptr_q;
          dataW    = out_w;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (c_q != CW'(WORDS - 1)) begin
          c_d     = c_q + 1'b1;
          state_d = RD;
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (r_q >= RW'(2)) begin
          en       = 1'b1;
          we       = 1'b1;
          addr     = wr_ptr_q;
          dataW    = out_w;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        c_d     = '0;
        r_d     = r_q + 1'b1;
        state_d = (r_q == RW'(IMG_H - 1)) ? ZBOT : RD;
      end
      DONE: begin
        finish = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      r_q      <= '0;
      c_q      <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      win_cur_q[i]  <= win_cur_d[i];
      win_left_q[i] <= win_left_d[i];
    end
  end

endmodule

// File: tb/tb_sobel_stream_acc.sv
// Directed bench for sobel_stream_acc on an 8x4 image with a behavioural
// single-port memory (one-cycle read latency).
module tb_sobel_stream_acc;
  import sobel_pkg::*;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 8;
  localparam int SRC    = 0;
  localparam int DST    = 8;
  localparam int NW     = IMG_W * IMG_H / 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dataR;
  logic [31:0]       dataW;
  logic              en;
  logic              we;
  logic              finish;

  logic [31:0] mem [256];
  int          rd_cnt [256];
  logic        tb_we;
  logic        tb_clr;
  logic [7:0]  tb_a;
  logic [31:0] tb_d;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  sobel_stream_acc #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .SRC_BASE (SRC),
    .DST_BASE (DST)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .dataR  (dataR),
    .dataW  (dataW),
    .en     (en),
    .we     (we),
    .start  (start),
    .finish (finish)
  );

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) rd_cnt[i] <= 0;
    end
    if (tb_we) begin
      mem[tb_a] <= tb_d;
    end else if (en) begin
      if (we) begin
        mem[addr] <= dataW;
      end else begin
        dataR        <= mem[addr];
        rd_cnt[addr] <= rd_cnt[addr] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    tb_a  = 8'(a);
    tb_d  = d;
    tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Rows 0-1 get (t0,t1), rows 2-3 get (b0,b1); destination is pre-poisoned.
  task automatic load(input logic [31:0] t0, input logic [31:0] t1,
                      input logic [31:0] b0, input logic [31:0] b1);
    for (int r = 0; r < IMG_H; r++) begin
      poke(SRC + 2*r,     (r < 2) ? t0 : b0);
      poke(SRC + 2*r + 1, (r < 2) ? t1 : b1);
    end
    for (int i = 0; i < NW; i++) poke(DST + i, 32'hDEADBEEF);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accept edge; bounded at 200.
  task automatic run(output int n);
    start = 1'b1;
    n     = 0;
    @(posedge clk);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (finish) break;
    end
  endtask

  task automatic check_rows(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    for (int r = 0; r < IMG_H; r++) begin
      check($sformatf("%s_r%0d_w0", tag, r), mem[DST + 2*r],
            (r == 0 || r == IMG_H - 1) ? 32'h0 : e0);
      check($sformatf("%s_r%0d_w1", tag, r), mem[DST + 2*r + 1],
            (r == 0 || r == IMG_H - 1) ? 32'h0 : e1);
    end
  endtask

  initial begin
    tb_we  = 1'b0;
    tb_clr = 1'b0;
    tb_a   = '0;
    tb_d   = '0;
    reset  = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en",     32'(en),     32'h0);
    check("rst_we",     32'(we),     32'h0);
    check("rst_finish", 32'(finish), 32'h0);
    check("rst_addr",   32'(addr),   32'h0);
    check("rst_dataW",  dataW,       32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Flat 0x80 image: all-zero output, 25-cycle latency, single reads.
    load(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080);
    run(lat);
    check("lat_flat", 32'(lat), 32'd25);
    check_rows("flat", 32'h0, 32'h0);
    for (int i = 0; i < NW; i++) check($sformatf("rdcnt_%0d", i), 32'(rd_cnt[SRC + i]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_finish", 32'(finish), 32'h1);
      check("hold_en",     32'(en),     32'h0);
    end
    start = 1'b0;
    @(negedge clk);
    check("drop_finish", 32'(finish), 32'h0);
    check("drop_state",  32'(dut.state_q), 32'(IDLE));

    // Vertical step between columns 3 and 4.
    load(32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    run(lat);
    check("lat_step", 32'(lat), 32'd25);
    check_rows("step", 32'hFF000000, 32'h000000FF);
    start = 1'b0;
    @(negedge clk);

    // Reset at cycle 10 of a run, then a horizontal ramp (10 per column).
    load(32'h1E140A00, 32'h463C3228, 32'h1E140A00, 32'h463C3228);
    start = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("mrst_en",     32'(en),     32'h0);
    check("mrst_we",     32'(we),     32'h0);
    check("mrst_finish", 32'(finish), 32'h0);
    check("mrst_state",  32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    load(32'h1E140A00, 32'h463C3228, 32'h1E140A00, 32'h463C3228);
    run(lat);
    check("lat_ramp", 32'(lat), 32'd25);
    check_rows("ramp", 32'h50505000, 32'h00505050);
    start = 1'b0;
    @(negedge clk);

    // Horizontal edge between rows 1 and 2: saturated Gy on both interior rows.
    load(32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(lat);
    check("lat_hedge", 32'(lat), 32'd25);
    check_rows("hedge", 32'hFFFFFF00, 32'h00FFFFFF);
    start = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_stream_acc.md
# sobel_stream_acc

Parametrised, streaming successor to the task-2 edge-detection accelerator. It reads a grey-scale image of IMG_W×IMG_H 8-bit pixels (4 pixels per 32-bit word) from the shared single-port memory, reading each input word exactly once. Two previous rows are held in internal line buffers. It applies the Sobel kernel to every interior pixel and writes the result image to a separate destination region, with all border pixels forced to zero. It sits in the same slot as the task-2 accelerator: memory bus on one side, start/finish handshake to the test harness on the other.

## Interface
- IMG_W, 352: image width in pixels; multiple of 4, ≥ 8.
- IMG_H, 288: image height in pixels; ≥ 3.
- ADDR_W, 16: word-address width.
- SRC_BASE, 0: word address of input pixel (0,0).
- DST_BASE, IMG_W*IMG_H/4: word address of output pixel (0,0).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  out  ADDR_W  word address.
- dataR  in  32  read data; valid the cycle after a read request.
- dataW  out  32  write data.
- en  out  1  memory request.
- we  out  1  1 = write, 0 = read; meaningful only when en=1.
- start  in  1  run request, level-sensitive.
- finish  out  1  run complete.
- thresh  in  8  binarisation threshold; present only with SOBEL_THRESH_EN.

## Operation
- WORDS = IMG_W/4. Byte k of a word is the pixel at column 4c+k (byte 0 = LSBs).
- States: IDLE, ZTOP, RD, WR, FLUSH, ZBOT, DONE.
- IDLE: en=we=0. When start=1, clear the row and column counters r and c, then go to ZTOP.
- ZTOP: write 0x00000000 to DST_BASE+0 … DST_BASE+WORDS-1, one word per cycle. Then go to RD with r=0, c=0.
- RD: read SRC_BASE + r·WORDS + c. Present line-buffer read address c. Go to WR.
- WR: capture dataR and both line-buffer words into a 3-row × 3-word window (prev, cur, new).
  - Line-buffer update: row1[c] moves to row0[c]; dataR goes to row1[c].
  - If r ≥ 2 and c ≥ 1, write output word (r-1, c-1) to DST_BASE + (r-1)·WORDS + c-1. Otherwise en=0.
  - If c < WORDS-1: c++, go to RD. Otherwise go to FLUSH.
- FLUSH: if r ≥ 2, write output word (r-1, WORDS-1), with the right-neighbour word treated as 0. Otherwise en=0.
  - c=0, r++. If r = IMG_H go to ZBOT, else go to RD.
- ZBOT: write zeros to the WORDS words of output row IMG_H-1. Then go to DONE.
- DONE: finish=1, en=0. Stay while start=1. When start=0, go to IDLE; finish drops in that cycle.
- Pixel rules:
  - Output column 0 and column IMG_W-1 are forced to 0x00.
  - The interior result comes from the existing sobel kernel, with 8-bit saturated magnitude.
  - Four kernel instances run in parallel, one per byte lane.
- Reset (reset=0 at a clock edge) from any state: the next state is IDLE, en=we=finish=0, and all counters clear. Line-buffer contents are don't-care. A partially written destination is not cleaned up.

## Timing
- Reset values: en=0, we=0, finish=0, addr=0, dataW=0.
- Outputs are decoded combinationally from registered state only; there is no combinational path from dataR to addr.
- In WR/FLUSH, dataW may depend combinationally on dataR.
- Memory accesses: one per cycle, never a read and a write in the same cycle.
- Per row: 2·WORDS+1 cycles.
- Cycles from the start-accept edge to the first cycle with finish=1: WORDS + IMG_H·(2·WORDS+1) + WORDS + 1.
  - 352×288: 51153.
  - 8×4: 25.
- Arithmetic:
  - Address counters are ADDR_W bits.
  - Addresses wrap modulo 2^ADDR_W; the integrator keeps the regions in range.
  - r and c are $clog2-sized counters.

## Configuration
- SOBEL_THRESH_EN defined:
  - Adds the thresh port.
  - Each interior output byte = (sobel ≥ thresh) ? 0xFF : 0x00.
  - Border bytes stay 0x00.
  - thresh is sampled every cycle and must be held stable during a run.
- SOBEL_THRESH_EN undefined: no thresh port; raw saturated magnitude is written.

## Structure
- Package sobel_pkg:
  - state enum state_t.
  - PIX_PER_WORD=4 and pixel_t/word_t typedefs.
  - Helper function unpacking a word into four pixel_t.
- Sub-module sobel_linebuf:
  - Two rows × WORDS × 32-bit.
  - Synchronous read one cycle after address, matching the memory latency.
  - Write-through shift row1 to row0 on write.
- The existing sobel kernel is reused unchanged (4 instances).

## Test plan
- 8×4, all input 0x80, start=1: destination words 0–7 all 0x00000000; finish first high exactly 25 cycles after start is accepted.
- 8×4, columns 0–3 = 0x00 and columns 4–7 = 0xFF: rows 1–2 read 0xFF000000 (word 0) and 0x000000FF (word 1); rows 0 and 3 read zero.
- Default 352×288 random image vs golden C model: DST 25344–50687 match byte-exact; finish at cycle 51153; each source word is read exactly once.
- reset=0 for one cycle mid-run (cycle 10 of 8×4): next cycle en=we=finish=0 and state IDLE. A following run gives correct output and 25-cycle latency.
- Start held high through DONE: finish stays 1 and no memory access occurs. Drop start: finish=0 next cycle; a new start re-runs.
- SOBEL_THRESH_EN with thresh=0x80 on a horizontal ramp: every output byte is 0x00 or 0xFF, with borders 0x00.
